// File: rtl/uart_transmitter.sv
// 8N1-style UART transmitter: valid/ready byte input into a small circular FIFO,
// frames sent LSB-first on a registered tx line, back-to-back without idle gaps.
module uart_transmitter #(
  parameter int DBITS      = 8,
  parameter int SBITS      = 1,
  parameter int BAUD_DIV   = 10416,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DBITS-1:0]                tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            tx,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int BDW  = $clog2(BAUD_DIV);
  localparam int MAXB = (DBITS > SBITS) ? DBITS : SBITS;
  localparam int BW   = $clog2(MAXB) + 1;

  localparam logic [BDW-1:0] BAUD_LAST  = BDW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]  DATA_LAST  = BW'(DBITS - 1);
  localparam logic [BW-1:0]  STOP_LAST  = BW'(SBITS - 1);
  localparam logic [CW-1:0]  FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [DBITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [1:0]       state;
  logic [BDW-1:0]   baud_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [DBITS-1:0] shift_reg;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             baud_done;
  logic [DBITS-1:0] head;

  assign tx_ready   = (fifo_count != FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);
  assign push       = tx_valid && tx_ready;
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign head       = mem[rd_ptr];
  assign tx_busy    = (state != IDLE);

  // The FSM pops either from IDLE or on the very last stop-bit cycle, which is
  // what lets consecutive frames abut with no idle cycle between them.
  assign pop = !fifo_empty &&
               ((state == IDLE) ||
                (state == STOP && baud_done && bit_cnt == STOP_LAST));

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // tx is loaded with the value of the bit being entered on the same edge as
  // the state change, so the pin never sees a decode glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift_reg <= head;
            bit_cnt   <= '0;
            state     <= START;
            tx        <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[DBITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
              tx      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (pop) begin
                shift_reg <= head;
                state     <= START;
                tx        <= 1'b0;
              end else begin
                state <= IDLE;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter that closes the loop with the receive path: it accepts bytes over a valid/ready handshake into a small FIFO and sends them LSB-first as 8N1-style frames on `tx`. It runs at the same bit rate as the receiver, 9600 baud from the 100 MHz system clock (BAUD_DIV = 10416). It sits between on-chip message/status logic, such as an echo or acknowledge generator, and the board's UART TX pin.

## Interface
- DBITS, 8, data bits per frame
- SBITS, 1, stop bits per frame (1 or 2)
- BAUD_DIV, 10416, clock cycles per bit; must be ≥ 2
- FIFO_DEPTH, 4, input FIFO entries; power of 2, ≥ 2

- clock  input  1  system clock; all logic on its rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- tx_data  input  DBITS  byte to send
- tx_valid  input  1  tx_data is valid this cycle
- tx_ready  output  1  FIFO can accept; push occurs when tx_valid && tx_ready
- tx  output  1  serial line; idles high; registered
- tx_busy  output  1  high while a frame is on the line (FSM not IDLE)
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently held

## Operation
- **FIFO**
  - Circular buffer with read/write pointers and a count register.
  - tx_ready = (fifo_count != FIFO_DEPTH), decoded from the registered count only.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
- **State machine**: IDLE, START, DATA, STOP.
  - **IDLE**: tx = 1. If fifo_count ≠ 0, pop the head into the shift register, clear baud_cnt and bit_cnt, go to START.
  - **START**: tx = 0 for BAUD_DIV cycles, then go to DATA.
  - **DATA**: tx = shift_reg[0]. On each baud_cnt == BAUD_DIV-1, shift right and increment bit_cnt. After DBITS bits, clear bit_cnt and go to STOP.
  - **STOP**: tx = 1 for SBITS×BAUD_DIV cycles, with bit_cnt counting stop bits.
    - On the final cycle, if the FIFO is non-empty, pop the next byte and go straight to START. This gives back-to-back frames with no extra idle cycle.
    - Otherwise go to IDLE.
- **Counters**
  - baud_cnt is $clog2(BAUD_DIV) bits wide and counts 0..BAUD_DIV-1, wrapping to 0 at each bit boundary. It is held at 0 in IDLE.
  - bit_cnt is $clog2(max(DBITS,SBITS))+1 bits wide.
- **Output register**: tx is driven from a register that is updated in the same cycle as the state transition, so there are no combinational glitches on the pin.
- **Reset values**
  - tx = 1, tx_busy = 0, tx_ready = 1, fifo_count = 0, state = IDLE.
  - Pointers, counters and shift register = 0.
- **Reset mid-frame**: the frame is aborted, tx returns high asynchronously, and FIFO contents are discarded.

## Timing
- A push in cycle N makes the entry visible in fifo_count at N+1.
- If the FSM is IDLE and the FIFO was empty:
  - the pop happens at N+1;
  - tx falls and tx_busy rises at N+2;
  - fifo_count returns to 0 at N+2.
- Frame length is exactly (1 + DBITS + SBITS) × BAUD_DIV cycles, measured from the tx falling edge to the first cycle that may start the next frame.
- Every bit holds for exactly BAUD_DIV cycles, with no ±1 drift across a frame.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- tx_busy falls on the first IDLE cycle. It stays high across back-to-back frames.
- Full FIFO: tx_ready = 0. A pop in that cycle does not allow a same-cycle push; tx_ready rises one cycle after the pop.
- tx_valid while tx_ready = 0: data is ignored and the FIFO is not modified.
- Throughput: FIFO_DEPTH+1 bytes can be absorbed back-to-back (one in the shift register, FIFO_DEPTH queued).

## Test plan
All scenarios use BAUD_DIV = 4 unless stated.

- **Reset state**: assert reset low mid-run, including during a DATA bit -> tx = 1, tx_busy = 0, tx_ready = 1, fifo_count = 0 immediately. Resume after release -> idle line, no spurious frame.
- **Single byte**: push 0xA5 -> tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. Total 40 cycles. tx_busy drops at cycle 42 after the push.
- **Back-to-back**: push 0x52, 0x33 on consecutive cycles -> two contiguous frames with no idle gap. A bench UART receiver at the same BAUD_DIV reads 0x52 then 0x33.
- **FIFO full / overflow**: with the line idle, push 6 bytes 0x00..0x05 on consecutive cycles:
  - tx_ready drops after the 5th push (one byte in the shift register, 4 queued);
  - the 6th push is ignored;
  - exactly 5 frames with values 0..4 are sent, in order.
- **Simultaneous push/pop**: time a push to coincide with the STOP→START pop while the FIFO holds 2 bytes -> fifo_count stays at 2 that cycle and the byte order is preserved.
- **Two stop bits, real rate**: SBITS = 2, BAUD_DIV = 10416, send 0xFF -> start low for 10416 cycles, then high for 10 × 10416 cycles. Line returns to idle, and the total frame is 11 × 10416 cycles.
